echo_unit: RTL

Stereo echo stage downstream of the music player, between its sample outputs and the codec. On each new-sample strobe it captures the left/right samples and reads a delayed sample pair from a circular buffer in block RAM. It mixes a decayed copy of the delayed pair into the dry pair, with saturation, and presents the result with a one-cycle valid pulse.

---
 rtl/echo_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/echo_unit.sv
// Stereo echo: mixes a decayed, delayed copy of each sample pair into the dry pair, with saturation.
// Latency: strobe on edge 0 -> registered outputs, buffer write and out_valid pulse from edge 2.
// Backpressure: none; strobes arriving in READ/MIX are dropped and set the sticky overrun flag.
// Optional feature: define ECHO_FEEDBACK_EN to store the mixed output (recirculating echo).
module echo_unit #(
  parameter int DELAY_SAMPLES = 4800,
  parameter int ADDR_WIDTH    = 13,
  parameter int DECAY_SHIFT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample_generated,
  input  logic [15:0] sample_in_left,
  input  logic [15:0] sample_in_right,
  input  logic        echo_on,
  output logic [15:0] sample_out_left,
  output logic [15:0] sample_out_right,
  output logic        out_valid,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, READ, MIX} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DELAY_SAMPLES - 1);

  state_t                state, state_next;
  logic                  accept, do_mix, busy_hit;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  primed;
  logic [15:0]           dry_left, dry_right;
  logic [31:0]           rd_data;
  logic [31:0]           wr_data;
  logic [15:0]           mix_left, mix_right;
  logic [31:0]           mem [0:DELAY_SAMPLES-1];

  // Dry sample plus attenuated delayed sample, clamped to the 16-bit signed range.
  function automatic logic [15:0] mix_sat(input logic [15:0] dry, input logic [15:0] delayed,
                                          input logic en);
    logic signed [15:0] e;
    logic signed [16:0] s;
    e = en ? ($signed(delayed) >>> DECAY_SHIFT) : 16'sd0;
    s = $signed({dry[15], dry}) + $signed({e[15], e});
    if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
    return s[15:0];
  endfunction

  // Echo is muted until the buffer has been filled once since reset.
  assign mix_left  = mix_sat(dry_left,  rd_data[31:16], echo_on & primed);
  assign mix_right = mix_sat(dry_right, rd_data[15:0],  echo_on & primed);

`ifdef ECHO_FEEDBACK_EN
  assign wr_data = {mix_left, mix_right};
`else
  assign wr_data = {dry_left, dry_right};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    do_mix     = 1'b0;
    busy_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (new_sample_generated) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        busy_hit   = new_sample_generated;
        state_next = MIX;
      end
      MIX: begin
        busy_hit   = new_sample_generated;
        do_mix     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer RAM: read the oldest entry on accept, overwrite the same slot in MIX.
  always_ff @(posedge clk) begin
    if (accept) rd_data <= mem[wr_ptr];
    if (do_mix && !reset) mem[wr_ptr] <= wr_data;
  end

  // Capture the dry pair on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      dry_left  <= '0;
      dry_right <= '0;
    end else if (accept) begin
      dry_left  <= sample_in_left;
      dry_right <= sample_in_right;
    end
  end

  // Output registers, valid pulse, pointer advance, primed and overrun flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out_left  <= '0;
      sample_out_right <= '0;
      out_valid        <= 1'b0;
      overrun          <= 1'b0;
      wr_ptr           <= '0;
      primed           <= 1'b0;
    end else begin
      out_valid <= do_mix;
      if (busy_hit) overrun <= 1'b1;
      if (do_mix) begin
        sample_out_left  <= mix_left;
        sample_out_right <= mix_right;
        if (wr_ptr == LAST_ADDR) begin
          wr_ptr <= '0;
          primed <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule
